// File: rtl/alu_wb_stage.sv
// ALU writeback stage: a two-entry in-order buffer between the ALU and the register file.
// It also holds the architectural NZCV flags, which are updated as flag-setting entries retire.
module alu_wb_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [RD_W-1:0]   alu_rd,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              alu_setf,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_we,
    output logic [3:0]        flags
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

    // NZCV is captured at push time so that retirement only has to copy bits.
    function automatic logic [3:0] calc_nzcv(
        input logic [DATA_W-1:0] res,
        input logic              c,
        input logic              v
    );
        calc_nzcv = {res[DATA_W-1], (res == {DATA_W{1'b0}}), c, v};
    endfunction

    state_t            state_r;
    logic [DATA_W-1:0] head_data_r;
    logic [RD_W-1:0]   head_rd_r;
    logic [3:0]        head_nzcv_r;
    logic              head_setf_r;
    logic [DATA_W-1:0] tail_data_r;
    logic [RD_W-1:0]   tail_rd_r;
    logic [3:0]        tail_nzcv_r;
    logic              tail_setf_r;
    logic [3:0]        flags_r;

    logic              push_s;
    logic              pop_s;
    logic [3:0]        new_nzcv_s;

    assign alu_ready  = (state_r != TWO);
    assign wb_valid   = (state_r != EMPTY);
    assign push_s     = alu_valid && alu_ready;
    assign pop_s      = wb_valid && wb_ready;
    assign new_nzcv_s = calc_nzcv(alu_result, alu_c, alu_v);

    assign wb_data = head_data_r;
    assign wb_rd   = head_rd_r;
    assign wb_we   = wb_valid && (head_rd_r != {RD_W{1'b0}});
    assign flags   = flags_r;

    // Buffer occupancy, entry storage and architectural flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            head_data_r <= {DATA_W{1'b0}};
            head_rd_r   <= {RD_W{1'b0}};
            head_nzcv_r <= 4'b0000;
            head_setf_r <= 1'b0;
            tail_data_r <= {DATA_W{1'b0}};
            tail_rd_r   <= {RD_W{1'b0}};
            tail_nzcv_r <= 4'b0000;
            tail_setf_r <= 1'b0;
            flags_r     <= 4'b0000;
        end else if (flush) begin
            // Anything in flight is abandoned, including a head retiring this cycle.
            state_r <= EMPTY;
        end else begin
            if (pop_s && head_setf_r) begin
                flags_r <= head_nzcv_r;
            end
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        head_data_r <= alu_result;
                        head_rd_r   <= alu_rd;
                        head_nzcv_r <= new_nzcv_s;
                        head_setf_r <= alu_setf;
                        state_r     <= ONE;
                    end
                end
                ONE: begin
                    case ({push_s, pop_s})
                        2'b10: begin
                            tail_data_r <= alu_result;
                            tail_rd_r   <= alu_rd;
                            tail_nzcv_r <= new_nzcv_s;
                            tail_setf_r <= alu_setf;
                            state_r     <= TWO;
                        end
                        2'b01: begin
                            state_r <= EMPTY;
                        end
                        2'b11: begin
                            head_data_r <= alu_result;
                            head_rd_r   <= alu_rd;
                            head_nzcv_r <= new_nzcv_s;
                            head_setf_r <= alu_setf;
                        end
                        default: begin
                            state_r <= ONE;
                        end
                    endcase
                end
                TWO: begin
                    if (pop_s) begin
                        head_data_r <= tail_data_r;
                        head_rd_r   <= tail_rd_r;
                        head_nzcv_r <= tail_nzcv_r;
                        head_setf_r <= tail_setf_r;
                        state_r     <= ONE;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end
    end

endmodule
